// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one AXI-stream floating-point divider between two
// requesters. Round-robin grant, held stable while an offer is unaccepted;
// an in-order tag FIFO records which port issued each operation so that the
// divider's results can be steered back to the right requester.
module fp_div_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MAX_OUT = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,

    input  logic                     req0_tvalid,
    output logic                     req0_tready,
    input  logic [WIDTH-1:0]         req0_a,
    input  logic [WIDTH-1:0]         req0_b,

    input  logic                     req1_tvalid,
    output logic                     req1_tready,
    input  logic [WIDTH-1:0]         req1_a,
    input  logic [WIDTH-1:0]         req1_b,

    output logic [WIDTH-1:0]         div_a_tdata,
    output logic [WIDTH-1:0]         div_b_tdata,
    output logic                     div_in_tvalid,
    input  logic                     div_in_tready,

    input  logic [WIDTH-1:0]         div_res_tdata,
    input  logic                     div_res_tvalid,
    output logic                     div_res_tready,

    output logic [WIDTH-1:0]         res0_tdata,
    output logic                     res0_tvalid,
    input  logic                     res0_tready,

    output logic [WIDTH-1:0]         res1_tdata,
    output logic                     res1_tvalid,
    input  logic                     res1_tready,

    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_orphan
);

    localparam int unsigned PW = $clog2(MAX_OUT);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        ARB_OPEN,
        ARB_HELD
    } arb_state_t;

    arb_state_t         state;
    arb_state_t         state_next;

    logic               lock_sel;
    logic               prio;
    logic               grant;
    logic               full;
    logic               in_valid;
    logic               issue;

    logic [CW-1:0]      wr_ptr;
    logic [CW-1:0]      rd_ptr;
    logic [MAX_OUT-1:0] tag_mem;
    logic               fifo_empty;
    logic               head;
    logic               pop;
    logic               orphan;

    // Issue-side qualifiers; outputs are forced low while reset is asserted.
    assign full     = (outstanding == CW'(MAX_OUT));
    assign in_valid = aresetn & (req0_tvalid | req1_tvalid) & ~full;
    assign issue    = in_valid & div_in_tready;

    assign div_in_tvalid = in_valid;
    assign req0_tready   = issue & ~grant;
    assign req1_tready   = issue & grant;
    assign div_a_tdata   = grant ? req1_a : req0_a;
    assign div_b_tdata   = grant ? req1_b : req0_b;

    // Grant select: held offer wins, otherwise single requester or priority.
    always_comb begin
        grant = 1'b0;
        if (state == ARB_HELD) begin
            grant = lock_sel;
        end else if (req0_tvalid && req1_tvalid) begin
            grant = prio;
        end else if (req1_tvalid) begin
            grant = 1'b1;
        end
    end

    // Next-state: hold the grant while an offer waits on the divider.
    always_comb begin
        state_next = state;
        case (state)
            ARB_OPEN: if (in_valid && !div_in_tready) state_next = ARB_HELD;
            ARB_HELD: if (issue) state_next = ARB_OPEN;
            default:  state_next = ARB_OPEN;
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ARB_OPEN;
        end else begin
            state <= state_next;
        end
    end

    // Captured grant for a stalled offer, and round-robin priority update.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock_sel <= 1'b0;
            prio     <= 1'b0;
        end else begin
            if (state == ARB_OPEN && in_valid && !div_in_tready) begin
                lock_sel <= grant;
            end
            if (issue) begin
                prio <= ~grant;
            end
        end
    end

    // Tag FIFO status: extra pointer bit separates full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = tag_mem[rd_ptr[PW-1:0]];

    // Result steering to the port named by the FIFO head; drop when empty.
    always_comb begin
        res0_tvalid    = 1'b0;
        res1_tvalid    = 1'b0;
        div_res_tready = 1'b0;
        if (aresetn) begin
            if (fifo_empty) begin
                div_res_tready = 1'b1;
            end else if (head) begin
                res1_tvalid    = div_res_tvalid;
                div_res_tready = res1_tready;
            end else begin
                res0_tvalid    = div_res_tvalid;
                div_res_tready = res0_tready;
            end
        end
    end

    assign res0_tdata = div_res_tdata;
    assign res1_tdata = div_res_tdata;

    assign pop    = div_res_tvalid & div_res_tready & ~fifo_empty;
    assign orphan = div_res_tvalid & div_res_tready & fifo_empty;

    // Tag FIFO pointers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (issue) wr_ptr <= wr_ptr + CW'(1);
            if (pop)   rd_ptr <= rd_ptr + CW'(1);
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge aclk) begin
        if (issue) begin
            tag_mem[wr_ptr[PW-1:0]] <= grant;
        end
    end

    // In-flight operation count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding <= '0;
        end else if (issue && !pop) begin
            outstanding <= outstanding + CW'(1);
        end else if (pop && !issue) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // Sticky flag for a result that had no matching tag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_orphan <= 1'b0;
        end else if (orphan) begin
            err_orphan <= 1'b1;
        end
    end

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Shares one AXI-stream floating-point divide operator between two requesters. In the Q-function datapath these are the ln(N)/T path and the X/T path, which otherwise need two divider instances. Requests are granted round-robin, and each issued operation's source port is recorded in an in-order tag FIFO. Each divider result is steered back to the requester that issued it.

## Interface
Parameters:
- WIDTH, 32, operand/result width (IEEE-754 single).
- MAX_OUT, 16, maximum operations in flight inside the divider; power of 2, ≥ divider latency for full throughput.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- req0_tvalid / req1_tvalid  in  1  requester i has an operand pair.
- req0_tready / req1_tready  out  1  requester i's pair accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  dividend, divisor.
- div_a_tdata, div_b_tdata  out  WIDTH  operands to divider; both operand channels driven together.
- div_in_tvalid  out  1  drives both divider operand tvalids.
- div_in_tready  in  1  AND of the divider's a/b tready.
- div_res_tdata  in  WIDTH  divider result.
- div_res_tvalid  in  1  divider result valid.
- div_res_tready  out  1  result accepted.
- res0_tdata / res1_tdata  out  WIDTH  quotient to requester i (both driven from div_res_tdata).
- res0_tvalid / res1_tvalid  out  1  result valid for requester i.
- res0_tready / res1_tready  in  1  requester i accepts.
- outstanding  out  $clog2(MAX_OUT)+1  operations issued, not yet returned.
- err_orphan  out  1  sticky: a result arrived with no outstanding tag.

## Operation
- Issue side:
  - full = (outstanding == MAX_OUT).
  - div_in_tvalid = (req0_tvalid | req1_tvalid) & ~full.
  - Issue = div_in_tvalid & div_in_tready.
- Grant is combinational when unlocked:
  - If only one port is valid, that port wins.
  - If both are valid, the port named by the priority bit `prio` wins (reset 0 = port 0).
- On issue, prio is set to the non-granted port.
- Lock, for AXI stability: if div_in_tvalid=1 and div_in_tready=0, the current grant is registered into lock_sel and locked=1. While locked:
  - the grant is lock_sel, whatever the other port does;
  - the lock clears on issue.
- Requesters must hold tvalid and data until their tready.
- reqi_tready = issue & (grant == i).
- div_a/b_tdata = mux(grant) of the request operands.
- Tag FIFO: MAX_OUT entries × 1 bit.
  - Push the grant index on issue.
  - Pop on div_res_tvalid & div_res_tready.
- Result steering, when the FIFO is not empty with head h:
  - res_h_tvalid = div_res_tvalid; the other res tvalid = 0.
  - div_res_tready = res_h_tready.
- FIFO empty and div_res_tvalid=1: div_res_tready=1, result dropped, err_orphan set to 1 until reset.
- outstanding:
  - +1 on issue only; −1 on pop only.
  - Unchanged on simultaneous issue and pop.
- Issue is blocked whenever full, even if a pop occurs in the same cycle.

## Timing
- Reset (async assert, sync release) sets:
  - outstanding=0, prio=0, locked=0, err_orphan=0, FIFO pointers 0;
  - all tvalid/tready outputs 0 while aresetn=0.
- Arbitration adds zero cycles: request to div_in_tvalid is combinational. An accepted pair costs one cycle of the divider input.
- Result path is combinational: div_res_* to res_i_* adds 0 cycles.
- End-to-end latency = divider latency.
- Throughput: one issue per cycle when not full, alternating ports under continuous contention.
- FIFO pointers wrap modulo MAX_OUT; the extra pointer bit distinguishes full from empty.
- Reset mid-operation discards all tags and lock state. The divider shares aresetn, so in-flight results are flushed with it.
- Result ordering is strictly issue order; the divider is in-order.

## Test plan
- Port 0 only: req0 a=0x40C00000 (6.0), b=0x40000000 (2.0) -> res0 delivers 0x40400000 (3.0); res1_tvalid stays 0; outstanding returns to 0.
- Both ports valid every cycle for 8 cycles, divider always ready -> grants alternate 0,1,0,1,…, starting with port 0 after reset. Results return in that order to the correct ports, each once.
- Port 1 valid, div_in_tready=0 for 3 cycles, port 0 raises tvalid in cycle 2 while prio=0 -> div_a/b_tdata stays on port 1's operands until accepted; port 0 is granted next.
- Hold res0_tready=0 with res0 at the FIFO head -> div_res_tready=0 and res1 is stalled behind it. Issue continues until outstanding=MAX_OUT (16), then div_in_tvalid=0.
- Pulse div_res_tvalid with outstanding=0 -> div_res_tready=1, no res tvalid, err_orphan=1 and stays 1.
- Assert aresetn=0 with 5 operations outstanding -> outstanding=0, err_orphan=0, all tvalid outputs 0 immediately. After release, the first grant goes to port 0.
